// File: rtl/step_debounce.sv
// step_debounce: single-step push-button front end.
// Turns the raw active-low "step" button into one clean, registered,
// fixed-width pulse per physical press. It also keeps a wrapping count of
// accepted presses and reports busy while a press/release is in flight.
module step_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  PULSE_CYCLES    = 8'd4,
    parameter int          CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_n,
    input  logic             run_mode,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PULSE        = 3'd2,
        HOLD         = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    // One counter is shared by the debounce and pulse-width phases. It is
    // wide enough for the larger of the two limits.
    localparam int CW = 16;

    localparam logic [CW-1:0] DEB_LAST   = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [CW-1:0] PULSE_LAST = {8'd0, PULSE_CYCLES} - 16'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [1:0]       sync;
    logic             btn_s;
    logic             deb_done, pulse_done;
    logic             count_inc;
    logic             pulse_nxt, busy_nxt;

    // The button is asynchronous, so it goes through two flops. The flops
    // hold the inverted level: a 1 means pressed, and reset means released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], ~step_n};
    end

    assign btn_s      = sync[1];
    assign deb_done   = (cnt == DEB_LAST);
    assign pulse_done = (cnt == PULSE_LAST);

    // State register. Pulse and busy are registered from the next state, so
    // they line up exactly with the state and cannot glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            step_count <= '0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            step_pulse <= pulse_nxt;
            busy       <= busy_nxt;
            if (count_inc) step_count <= step_count + CNT_ONE;
        end
    end

    // Next-state logic. PULSE ignores every input so a started pulse always
    // runs to full width. run_mode only gates the start of a new press.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!run_mode && btn_s) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s)        state_nxt = IDLE;
                else if (run_mode) state_nxt = IDLE;
                else if (deb_done) state_nxt = PULSE;
            end
            PULSE: begin
                if (pulse_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (!btn_s) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_s)         state_nxt = HOLD;
                else if (deb_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath controls. The counter restarts at 0 on every state change and
    // advances only while the state waits on it.
    always_comb begin
        cnt_nxt   = '0;
        count_inc = 1'b0;
        pulse_nxt = (state_nxt == PULSE);
        busy_nxt  = (state_nxt != IDLE);
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == PRESS_WAIT || state == PULSE ||
                     state == RELEASE_WAIT) begin
            cnt_nxt = cnt + 16'd1;
        end
        if (state == PRESS_WAIT && state_nxt == PULSE) count_inc = 1'b1;
    end

endmodule

// File: tb/tb_step_debounce.sv
// Bench for step_debounce with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, CNT_W=4.
// A negedge monitor pops the expected pulses that the stimulus pushes. It
// checks the rise edge, the count at the rise and the pulse width. Any pulse
// the monitor does not expect is flagged.
module tb_step_debounce;

    localparam int DEB = 4;
    localparam int PW  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_n = 1'b1;
    logic       run_mode = 1'b0;
    logic       step_pulse;
    logic [3:0] step_count;
    logic       busy;

    step_debounce #(
        .DEBOUNCE_CYCLES(16'd4),
        .PULSE_CYCLES   (8'd2),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step_n    (step_n),
        .run_mode  (run_mode),
        .step_pulse(step_pulse),
        .step_count(step_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int rise;
        int cnt;
    } exp_t;
    exp_t q[$];

    // Monitor for pulse rises and widths. Any reset cancels a pulse in progress.
    logic prev = 1'b0;
    int   width = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev  = 1'b0;
            width = 0;
        end else begin
            if (step_pulse && !prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rise_cyc", cyc, e.rise);
                    chk("count_at_rise", int'(step_count), e.cnt);
                end
                width = 1;
            end else if (step_pulse) begin
                width++;
            end else if (prev) begin
                chk("pulse_width", width, PW);
            end
            prev = step_pulse;
        end
    end

    typedef struct {
        int bounce;
        int hold;
        bit rm;
        bit rel_bounce;
        bit exp_pulse;
    } vec_t;
    vec_t vt[$];

    int exp_cnt = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start a press, optionally after a bouncing lead-in. Returns the edge
    // after which step_n settled low.
    task automatic press(input int bounce, input bit expect_pulse, output int c0);
        exp_t e;
        for (int i = 0; i < bounce; i++) begin
            step_n = ((i / 2) % 2) != 0;
            tick(1);
        end
        step_n = 1'b0;
        c0 = cyc;
        if (expect_pulse) begin
            exp_cnt = (exp_cnt + 1) % 16;
            e.rise = c0 + 3 + DEB;
            e.cnt  = exp_cnt;
            q.push_back(e);
        end
    endtask

    // Release the button, optionally with one bounce. Then check that busy
    // drops exactly DEB+3 edges after the final release.
    task automatic release_chk(input bit bounce, input bit was_busy);
        int f;
        step_n = 1'b1;
        if (bounce) begin
            tick(2);
            step_n = 1'b0;
            tick(1);
            step_n = 1'b1;
        end
        f = cyc;
        tick(DEB + 2);
        chk("busy_before_idle", int'(busy), int'(was_busy));
        tick(1);
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(1);
            if (step_pulse) ok = 1'b1;
        end
    endtask

    initial begin
        int c0;
        bit ok;

        vt.push_back('{bounce: 0,  hold: 30, rm: 1'b0, rel_bounce: 1'b0, exp_pulse: 1'b1});
        vt.push_back('{bounce: 20, hold: 20, rm: 1'b0, rel_bounce: 1'b0, exp_pulse: 1'b1});
        vt.push_back('{bounce: 0,  hold: 12, rm: 1'b0, rel_bounce: 1'b1, exp_pulse: 1'b1});
        vt.push_back('{bounce: 0,  hold: 20, rm: 1'b1, rel_bounce: 1'b0, exp_pulse: 1'b0});
        for (int i = 0; i < 16; i++)
            vt.push_back('{bounce: 0, hold: 12, rm: 1'b0, rel_bounce: 1'b0, exp_pulse: 1'b1});

        #3;
        chk("rst_pulse", int'(step_pulse), 0);
        chk("rst_count", int'(step_count), 0);
        chk("rst_busy", int'(busy), 0);
        tick(2);
        reset = 1'b0;
        tick(3);

        foreach (vt[i]) begin
            run_mode = vt[i].rm;
            press(vt[i].bounce, vt[i].exp_pulse, c0);
            tick(vt[i].hold);
            chk("busy_hold", int'(busy), int'(vt[i].exp_pulse));
            chk("count_hold", int'(step_count), exp_cnt);
            release_chk(vt[i].rel_bounce, vt[i].exp_pulse);
            run_mode = 1'b0;
            tick(2);
        end

        // Switch to free-run on the first pulse cycle. The pulse still runs to
        // full width, and the release path completes normally.
        press(0, 1'b1, c0);
        wait_pulse(ok);
        chk("rm_pulse_seen", int'(ok), 1);
        chk("rm_pulse_edge", cyc, c0 + 3 + DEB);
        run_mode = 1'b1;
        tick(10);
        chk("rm_count", int'(step_count), exp_cnt);
        release_chk(1'b0, 1'b1);
        run_mode = 1'b0;
        tick(2);

        // Assert reset in the middle of a pulse. The outputs clear at once. With
        // the button still held, a fresh debounce produces a new pulse.
        press(0, 1'b0, c0);
        wait_pulse(ok);
        chk("rst_pulse_seen", int'(ok), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pulse", int'(step_pulse), 0);
        chk("mid_rst_count", int'(step_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        exp_cnt = 0;
        tick(1);
        reset = 1'b0;
        begin
            exp_t e;
            exp_cnt = 1;
            e.rise = cyc + 3 + DEB;
            e.cnt  = exp_cnt;
            q.push_back(e);
        end
        tick(14);
        chk("post_rst_count", int'(step_count), 1);
        release_chk(1'b0, 1'b1);

        tick(4);
        chk("pending_pulses", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
